// File: rtl/corelet_seq_ctrl.sv
// Sequencer for one corelet: drives inst_w/load/rd/os and the activation/weight SRAM reads.
// WS mode loops clear/load/settle/exec/drain per kernel position; OS mode is one clear/stream/flush.
module corelet_seq_ctrl #(
   parameter int unsigned row           = 8,
   parameter int unsigned col           = 8,
   parameter int unsigned kij_len       = 9,
   parameter int unsigned nij_len       = 36,
   parameter int unsigned os_len        = 16,
   parameter int unsigned act_aw        = 11,
   parameter int unsigned w_aw          = 11,
   parameter int unsigned drain_timeout = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              os_sel,
   input  logic              corelet_valid,
   output logic [1:0]        inst_w,
   output logic              load,
   output logic              rd,
   output logic              os,
   output logic [act_aw-1:0] act_addr,
   output logic              act_cen,
   output logic [w_aw-1:0]   w_addr,
   output logic              w_cen,
   output logic [3:0]        kij_idx,
   output logic              busy,
   output logic              done,
   output logic              err
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // One step counter is shared by every timed state, so it covers the largest bound
   localparam int unsigned StepMax = max2(max2(max2(row, col), max2(nij_len, os_len)),
                                          max2(row + col, drain_timeout));
   localparam int unsigned StepW   = $clog2(StepMax) + 1;
   localparam int unsigned VldW    = $clog2(nij_len) + 1;

   localparam logic [1:0] InstIdle = 2'b00;
   localparam logic [1:0] InstLoad = 2'b01;
   localparam logic [1:0] InstExec = 2'b10;

   typedef enum logic [3:0] {
      StIdle,
      StClr,
      StKload,
      StSettle,
      StExec,
      StDrain,
      StOstream,
      StOflush,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [StepW-1:0]  step_q, step_d;
   logic [VldW-1:0]   vld_q, vld_d;
   logic [3:0]        kij_q, kij_d, kij_inc;
   logic [act_aw-1:0] act_addr_q, act_addr_d;
   logic [w_aw-1:0]   w_addr_q, w_addr_d;
   logic              os_q, os_d;
   logic              err_q, err_d;

   logic [1:0]        inst_w_q, inst_w_d;
   logic              load_q, load_d;
   logic              rd_q, rd_d;
   logic              act_cen_q, act_cen_d;
   logic              w_cen_q, w_cen_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      vld_d      = vld_q;
      kij_d      = kij_q;
      act_addr_d = act_addr_q;
      w_addr_d   = w_addr_q;
      os_d       = os_q;
      err_d      = err_q;
      kij_inc    = kij_q + 4'd1;

      // Pulses count from EXEC entry through DRAIN and saturate at nij_len
      if ((state_q == StExec || state_q == StDrain) && corelet_valid &&
          (vld_q != VldW'(nij_len))) begin
         vld_d = vld_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StClr;
               os_d       = os_sel;
               err_d      = 1'b0;
               kij_d      = '0;
               act_addr_d = '0;
               w_addr_d   = '0;
               step_d     = '0;
            end
         end
         StClr: begin
            step_d  = '0;
            state_d = os_q ? StOstream : StKload;
         end
         StKload: begin
            w_addr_d = w_addr_q + 1'b1;
            if (step_q == StepW'(row - 1)) begin
               step_d  = '0;
               state_d = StSettle;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         StSettle: begin
            if (step_q == StepW'(col - 1)) begin
               step_d     = '0;
               state_d    = StExec;
               act_addr_d = '0;
               vld_d      = '0;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         StExec: begin
            act_addr_d = act_addr_q + 1'b1;
            if (step_q == StepW'(nij_len - 1)) begin
               step_d  = '0;
               state_d = StDrain;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         StDrain: begin
            // A full set of outputs wins over a timeout landing on the same cycle
            if (vld_q == VldW'(nij_len)) begin
               step_d  = '0;
               kij_d   = kij_inc;
               state_d = (kij_inc == 4'(kij_len)) ? StDone : StClr;
            end else if (step_q == StepW'(drain_timeout - 1)) begin
               step_d  = '0;
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         StOstream: begin
            act_addr_d = act_addr_q + 1'b1;
            w_addr_d   = w_addr_q + 1'b1;
            if (step_q == StepW'(os_len - 1)) begin
               step_d  = '0;
               state_d = StOflush;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         StOflush: begin
            if (step_q == StepW'(row + col - 1)) begin
               step_d  = '0;
               state_d = StDone;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are decoded from the next state so they leave the flops aligned with state_q
   always_comb begin
      inst_w_d  = InstIdle;
      load_d    = 1'b0;
      rd_d      = 1'b0;
      act_cen_d = 1'b1;
      w_cen_d   = 1'b1;
      busy_d    = (state_d != StIdle);
      done_d    = 1'b0;

      unique case (state_d)
         StClr: begin
            load_d = 1'b1;
         end
         StKload: begin
            inst_w_d = InstLoad;
            w_cen_d  = 1'b0;
         end
         StExec: begin
            inst_w_d  = InstExec;
            act_cen_d = 1'b0;
            rd_d      = (kij_d != 4'd0);
         end
         StOstream: begin
            inst_w_d  = InstLoad;
            act_cen_d = 1'b0;
            w_cen_d   = 1'b0;
         end
         StDone: begin
            done_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         step_q     <= '0;
         vld_q      <= '0;
         kij_q      <= '0;
         act_addr_q <= '0;
         w_addr_q   <= '0;
         os_q       <= 1'b0;
         err_q      <= 1'b0;
         inst_w_q   <= InstIdle;
         load_q     <= 1'b0;
         rd_q       <= 1'b0;
         act_cen_q  <= 1'b1;
         w_cen_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         vld_q      <= vld_d;
         kij_q      <= kij_d;
         act_addr_q <= act_addr_d;
         w_addr_q   <= w_addr_d;
         os_q       <= os_d;
         err_q      <= err_d;
         inst_w_q   <= inst_w_d;
         load_q     <= load_d;
         rd_q       <= rd_d;
         act_cen_q  <= act_cen_d;
         w_cen_q    <= w_cen_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign inst_w   = inst_w_q;
   assign load     = load_q;
   assign rd       = rd_q;
   assign os       = os_q;
   assign act_addr = act_addr_q;
   assign act_cen  = act_cen_q;
   assign w_addr   = w_addr_q;
   assign w_cen    = w_cen_q;
   assign kij_idx  = kij_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_corelet_seq_ctrl.sv
// Bench for corelet_seq_ctrl: builds the expected per-cycle trace of each run from the
// phase rules and a randomized valid-pulse schedule, then compares the DUT cycle by cycle.
module tb_corelet_seq_ctrl;

   localparam int ROW = 8;
   localparam int COL = 8;
   localparam int KIJ = 9;
   localparam int NIJ = 36;
   localparam int OSL = 16;
   localparam int TMO = 64;
   localparam int VS  = 4096;

   typedef struct packed {
      logic [1:0]  inst_w;
      logic        load;
      logic        rd;
      logic        os;
      logic        act_cen;
      logic        w_cen;
      logic        busy;
      logic        done;
      logic        err;
      logic [3:0]  kij;
      logic [10:0] act_addr;
      logic [10:0] w_addr;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        os_sel;
   logic        corelet_valid;
   logic [1:0]  inst_w;
   logic        load, rd, os, act_cen, w_cen, busy, done, err;
   logic [10:0] act_addr, w_addr;
   logic [3:0]  kij_idx;
   obs_t        dut_obs;

   corelet_seq_ctrl #(
      .row           (ROW),
      .col           (COL),
      .kij_len       (KIJ),
      .nij_len       (NIJ),
      .os_len        (OSL),
      .act_aw        (11),
      .w_aw          (11),
      .drain_timeout (TMO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .os_sel        (os_sel),
      .corelet_valid (corelet_valid),
      .inst_w        (inst_w),
      .load          (load),
      .rd            (rd),
      .os            (os),
      .act_addr      (act_addr),
      .act_cen       (act_cen),
      .w_addr        (w_addr),
      .w_cen         (w_cen),
      .kij_idx       (kij_idx),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   always #5 clk = ~clk;

   assign dut_obs = {inst_w, load, rd, os, act_cen, w_cen, busy, done, err, kij_idx,
                     act_addr, w_addr};

   int   n_cmp = 0;
   int   n_bad = 0;
   obs_t plan[$];
   bit   vsched[0:VS-1];
   int   exec3_t;
   int   exp_len;
   int   cnt_load, cnt_k, cnt_x, cnt_rd, cnt_done, cnt_busy;

   // Model state carried between runs: these are the values the outputs hold
   logic        m_os, m_err;
   logic [3:0]  m_kij;
   logic [10:0] m_aa, m_wa;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic obs_t mk(input logic [1:0] iw, input logic ld, input logic r,
                               input logic ac, input logic wc, input logic b, input logic d);
      obs_t o;
      o.inst_w   = iw;
      o.load     = ld;
      o.rd       = r;
      o.os       = m_os;
      o.act_cen  = ac;
      o.w_cen    = wc;
      o.busy     = b;
      o.done     = d;
      o.err      = m_err;
      o.kij      = m_kij;
      o.act_addr = m_aa;
      o.w_addr   = m_wa;
      return o;
   endfunction

   // Trace entry i is cycle i+1 after the start cycle; vsched is indexed by that cycle number
   task automatic plan_ws(input int lat_fix, input bit gaps, input int short_kij, input int extra);
      int t, te, pt, p36, lat, np, ds, ex, nd;
      bit to;
      plan.delete();
      for (int i = 0; i < VS; i++) vsched[i] = 1'b0;
      m_os = 1'b0; m_err = 1'b0; m_kij = 4'd0; m_aa = 11'd0; m_wa = 11'd0;
      t = 1;
      exec3_t = -1;
      exp_len = 2;
      for (int k = 0; k < KIJ; k++) begin
         plan.push_back(mk(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
         t++;
         for (int j = 0; j < ROW; j++) begin
            plan.push_back(mk(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
            m_wa++;
            t++;
         end
         for (int j = 0; j < COL; j++) begin
            plan.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
            t++;
         end
         te = t;
         if (k == 3) exec3_t = t;
         for (int j = 0; j < NIJ; j++) begin
            m_aa = 11'(j);
            plan.push_back(mk(2'b10, 1'b0, (k != 0), 1'b0, 1'b1, 1'b1, 1'b0));
            t++;
         end
         m_aa = 11'(NIJ);
         lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 12));
         np  = (k == short_kij) ? NIJ - 1 : NIJ + extra;
         pt  = te + lat;
         p36 = -1;
         for (int i = 0; i < np; i++) begin
            vsched[pt] = 1'b1;
            if (i == NIJ - 1) p36 = pt;
            pt += 1 + ((gaps && ($urandom_range(0, 3) == 0)) ? 1 : 0);
         end
         // DRAIN leaves the cycle after the 36th pulse, but no earlier than its first cycle
         ds = t;
         to = !(p36 >= 0 && p36 + 1 <= ds + TMO - 1);
         ex = to ? ds + TMO - 1 : ((p36 + 1 > ds) ? p36 + 1 : ds);
         nd = ex - ds + 1;
         for (int d = 0; d < nd; d++) begin
            plan.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
            t++;
         end
         exp_len += 1 + ROW + COL + NIJ + nd;
         if (to) begin
            m_err = 1'b1;
            break;
         end
         m_kij++;
      end
      plan.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
      plan.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
   endtask

   task automatic plan_os();
      plan.delete();
      for (int i = 0; i < VS; i++) vsched[i] = 1'b0;
      m_os = 1'b1; m_err = 1'b0; m_kij = 4'd0; m_aa = 11'd0; m_wa = 11'd0;
      plan.push_back(mk(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      for (int j = 0; j < OSL; j++) begin
         m_aa = 11'(j);
         m_wa = 11'(j);
         plan.push_back(mk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      end
      m_aa = 11'(OSL);
      m_wa = 11'(OSL);
      for (int j = 0; j < ROW + COL; j++)
         plan.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      plan.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
      plan.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      for (int t = 1; t <= plan.size(); t++) vsched[t] = 1'($urandom_range(0, 1));
      exp_len = 1 + 1 + OSL + ROW + COL + 1;
   endtask

   task automatic run_plan(input bit hold, input int abort_at);
      cnt_load = 0; cnt_k = 0; cnt_x = 0; cnt_rd = 0; cnt_done = 0; cnt_busy = 0;
      @(posedge clk);
      #1;
      start         = 1'b1;
      corelet_valid = 1'b0;
      for (int idx = 0; idx < plan.size(); idx++) begin
         @(posedge clk);
         #1;
         start         = hold && (idx < plan.size() - 1);
         corelet_valid = vsched[idx + 1];
         @(negedge clk);
         chk($sformatf("trace_cycle%0d", idx + 1), 64'(dut_obs), 64'(plan[idx]));
         cnt_load += int'(load);
         cnt_k    += (inst_w == 2'b01) ? 1 : 0;
         cnt_x    += (inst_w == 2'b10) ? 1 : 0;
         cnt_rd   += int'(rd);
         cnt_done += int'(done);
         cnt_busy += int'(busy);
         if (idx + 1 == abort_at) break;
      end
      start         = 1'b0;
      corelet_valid = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      os_sel        = 1'b0;
      corelet_valid = 1'b0;
      m_os = 1'b0; m_err = 1'b0; m_kij = 4'd0; m_aa = 11'd0; m_wa = 11'd0;
      #1 reset = 1'b0;
      #1 chk("reset_state", 64'(dut_obs), 64'(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)));
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // WS, valid returned 10 cycles after each execute cycle
      os_sel = 1'b0;
      plan_ws(10, 1'b0, -1, 0);
      run_plan(1'b0, -1);
      chk("ws_load_pulses", 64'(cnt_load), 64'(KIJ));
      chk("ws_kload_cycles", 64'(cnt_k), 64'(KIJ * ROW));
      chk("ws_exec_cycles", 64'(cnt_x), 64'(KIJ * NIJ));
      chk("ws_rd_cycles", 64'(cnt_rd), 64'((KIJ - 1) * NIJ));
      chk("ws_done_pulses", 64'(cnt_done), 64'd1);
      chk("ws_run_length", 64'(cnt_busy + 1), 64'(exp_len));
      chk("ws_run_length_fixed", 64'(cnt_busy + 1), 64'(1 + KIJ * (1 + ROW + COL + NIJ + 11) + 1));
      chk("ws_w_addr_final", 64'(w_addr), 64'(ROW * KIJ));
      chk("ws_err", 64'(err), 64'd0);

      // OS run with random (ignored) valid pulses
      os_sel = 1'b1;
      plan_os();
      run_plan(1'b0, -1);
      os_sel = 1'b0;
      chk("os_load_pulses", 64'(cnt_load), 64'd1);
      chk("os_stream_cycles", 64'(cnt_k), 64'(OSL));
      chk("os_rd_cycles", 64'(cnt_rd), 64'd0);
      chk("os_done_pulses", 64'(cnt_done), 64'd1);
      chk("os_run_length", 64'(cnt_busy + 1), 64'(exp_len));
      chk("os_latched", 64'(os), 64'd1);

      // WS with 35 pulses in kij 0: drain timeout
      plan_ws(-1, 1'b1, 0, 0);
      run_plan(1'b0, -1);
      chk("to_done_pulses", 64'(cnt_done), 64'd1);
      chk("to_run_length", 64'(cnt_busy + 1), 64'(1 + (1 + ROW + COL + NIJ + TMO) + 1));
      repeat (5) begin
         @(negedge clk);
         chk("to_err_sticky", 64'({err, kij_idx, busy}), 64'({1'b1, 4'd0, 1'b0}));
      end

      // start held high through the whole run, including DRAIN
      plan_ws(-1, 1'b1, -1, 0);
      run_plan(1'b1, -1);
      chk("hold_done_pulses", 64'(cnt_done), 64'd1);
      chk("hold_load_pulses", 64'(cnt_load), 64'(KIJ));
      repeat (3) begin
         @(negedge clk);
         chk("hold_idle_after", 64'({busy, done, kij_idx}), 64'({1'b0, 1'b0, 4'(KIJ)}));
      end

      // Asynchronous reset during EXEC of kij 3
      plan_ws(-1, 1'b0, -1, 0);
      run_plan(1'b0, exec3_t + 5);
      chk("pre_reset_kij", 64'(kij_idx), 64'd3);
      chk("pre_reset_exec", 64'(inst_w), 64'd2);
      #2 reset = 1'b0;
      m_os = 1'b0; m_err = 1'b0; m_kij = 4'd0; m_aa = 11'd0; m_wa = 11'd0;
      #1 chk("reset_async", 64'(dut_obs), 64'(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)));
      repeat (3) begin
         @(negedge clk);
         chk("reset_hold", 64'({busy, done}), 64'd0);
      end
      reset = 1'b1;

      // Fresh run: pulses start in the first EXEC cycle, with extras beyond nij_len
      plan_ws(0, 1'b1, -1, 3);
      run_plan(1'b0, -1);
      chk("extra_done_pulses", 64'(cnt_done), 64'd1);
      chk("extra_kij_final", 64'(kij_idx), 64'(KIJ));
      chk("extra_run_length", 64'(cnt_busy + 1), 64'(exp_len));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/corelet_seq_ctrl.md
Name: corelet_seq_ctrl

Overview:
Sequencer that drives the corelet control inputs: inst_w, load, rd and os. It also generates activation and weight SRAM read addresses.
- Weight-stationary (WS) mode: loops over kij_len kernel positions. Each iteration is clear, weight load, settle, nij_len-cycle activation stream, and drain until all nij_len OFIFO outputs have appeared.
- Output-stationary (OS) mode: a single clear, stream and flush pass.
- Sits between the top-level testbench/host and the corelet; one instance per corelet.

Parameters:
row, 8, PE rows (weight-load cycles per kij)
col, 8, PE columns (settle/flush depth)
kij_len, 9, kernel positions per WS run
nij_len, 36, activation vectors streamed per kij
os_len, 16, OS stream cycles
act_aw, 11, activation SRAM address width
w_aw, 11, weight SRAM address width
drain_timeout, 64, max DRAIN cycles before error

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle run request, sampled only in IDLE
os_sel  input  1  mode for the run: 0 = WS, 1 = OS; latched at start
corelet_valid  input  1  corelet valid (OFIFO output valid), one pulse per output vector
inst_w  output  2  corelet instruction: 01 = kernel load, 10 = execute, 00 = idle
load  output  1  corelet array clear
rd  output  1  OFIFO psum feedback enable
os  output  1  latched mode to corelet
act_addr  output  act_aw  activation SRAM address
act_cen  output  1  activation SRAM chip enable, active-low
w_addr  output  w_aw  weight SRAM address
w_cen  output  1  weight SRAM chip enable, active-low
kij_idx  output  4  current kernel position
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on run completion
err  output  1  sticky drain-timeout flag, cleared by the next accepted start

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE;
  - inst_w=00; load=0; rd=0; os=0; done=0; err=0;
  - act_cen=1; w_cen=1; busy=0;
  - all counters and addresses to 0.
- All outputs are registered and change only on clk rise, except during reset.
- Reset mid-run abandons the run; no done pulse is produced.
- IDLE:
  - start=1 latches os_sel into os, clears err, zeroes kij_idx and both addresses, then goes to CLR.
  - start=0 holds IDLE. start in any other state is ignored.
- CLR: load=1 for exactly 1 cycle, then goes to KLOAD in WS or OSTREAM in OS.
- KLOAD (WS):
  - row cycles with inst_w=01, w_cen=0; w_addr increments by 1 each cycle.
  - w_addr is not reset between kijs; after a run it equals row*kij_len.
  - Then goes to SETTLE.
- SETTLE (WS): col cycles with inst_w=00, then EXEC.
- EXEC (WS):
  - nij_len cycles with inst_w=10, act_cen=0; act_addr increments each cycle.
  - act_addr restarts at 0 on entry to every EXEC.
  - rd=1 throughout EXEC when kij_idx!=0; otherwise rd=0.
  - Then goes to DRAIN.
- DRAIN (WS):
  - inst_w=00. A valid counter counts corelet_valid pulses since entry to EXEC, including any that arrive during EXEC.
  - When the count reaches nij_len: kij_idx increments. If the new kij_idx==kij_len, go to DONE; otherwise go to CLR.
  - If drain_timeout cycles pass in DRAIN without reaching nij_len: set err=1 and go to DONE.
  - Valid pulses beyond nij_len are ignored; the counter saturates.
- OSTREAM (OS):
  - os_len cycles with inst_w=01; act_cen=0 and w_cen=0; act_addr and w_addr both increment.
  - rd=0 for the whole OS run.
  - Then goes to OFLUSH.
- OFLUSH (OS): row+col cycles with inst_w=00, then DONE. corelet_valid is ignored in OS.
- DONE: done=1 for 1 cycle, busy=1, then IDLE.
- Counter widths are clog2 of their bound plus 1. No wrap-around occurs within legal parameters.
- Total WS run length = 1 + kij_len*(1+row+col+nij_len+D) + 1 cycles, where D is the number of DRAIN cycles per kij.

Test Plan:
- Reset during EXEC of kij 3 -> all outputs return to reset values immediately, with no clock; busy=0; no done pulse; a fresh start then runs from kij_idx=0.
- WS run with default parameters and corelet_valid returned 10 cycles after each execute cycle -> 9 load pulses; 9×8 cycles of inst_w=01; 9×36 cycles of inst_w=10. Final w_addr=72; done pulses once; err=0; rd low during kij 0 EXEC and high in kijs 1-8.
- OS run (os_sel=1) -> a single load pulse; 16 cycles of inst_w=01 with both addresses counting 0..15; 16 flush cycles; done; rd=0 throughout; os=1 for the whole run.
- WS run with only 35 valid pulses in kij 0 -> after 64 DRAIN cycles err=1 and done pulses; kij_idx=0; err stays high until the next start.
- start held high for the whole run and asserted during DRAIN -> exactly one run executes; a new run begins only after returning to IDLE.
- Valid pulses arriving during EXEC and more than nij_len per kij -> pulses arriving during EXEC are counted; DRAIN exits the cycle after the 36th pulse; extra pulses do not advance kij_idx.
